// File: rtl/present_decrypt_pkg.sv
// Shared PRESENT constants: block/key widths, S-box tables, pLayer index.
package present_decrypt_pkg;
  localparam int KEY_W = 80;
  localparam int BLOCK_W = 64;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  localparam logic [3:0] INV_SBOX [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    WHITEN,
    DECRYPT
  } state_t;

  function automatic int p_idx(input int j);
    return (j == 63) ? 63 : 16 * (j % 4) + j / 4;
  endfunction
endpackage

// File: rtl/data_restore.sv
// One inverse PRESENT round: invP, invS, then add round key.
module data_restore
  import present_decrypt_pkg::*;
(
  input  logic [BLOCK_W-1:0] Data_ib,
  input  logic [BLOCK_W-1:0] RoundKey_ib,
  output logic [BLOCK_W-1:0] Data_ob
);
  logic [BLOCK_W-1:0] unperm;
  logic [BLOCK_W-1:0] unsub;

  for (genvar j = 0; j < BLOCK_W; j++) begin : g_perm
    assign unperm[j] = Data_ib[p_idx(j)];
  end

  for (genvar n = 0; n < BLOCK_W / 4; n++) begin : g_sbox
    inv_s_box u_sb (
      .nibble(unperm[4*n +: 4]),
      .result(unsub[4*n +: 4])
    );
  end

  assign Data_ob = unsub ^ RoundKey_ib;
endmodule

// File: rtl/inv_s_box.sv
// PRESENT inverse S-box, one nibble.
module inv_s_box
  import present_decrypt_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [3:0] result
);
  assign result = INV_SBOX[nibble];
endmodule

// File: rtl/present_decrypt.sv
// Iterative PRESENT-80 decryption: forward key expansion, whitening,
// then one inverse round per clock.
module present_decrypt
  import present_decrypt_pkg::*;
#(
  parameter int ROUNDS = 31
) (
  input  logic               Clk_ik,
  input  logic               Reset_ir,
  input  logic               Start_i,
  input  logic [KEY_W-1:0]   Key_ib,
  input  logic [BLOCK_W-1:0] Cipher_ib,
  output logic [BLOCK_W-1:0] Data_ob,
  output logic               Busy_o,
  output logic               Done_o
);
  localparam logic [4:0] RMAX = 5'(ROUNDS);

  state_t cur, nxt;
  logic [BLOCK_W-1:0] st;
  logic [BLOCK_W-1:0] restored;
  logic [KEY_W-1:0]   key;
  logic [4:0]         rc;

  function automatic logic [KEY_W-1:0] fwd_upd(
    input logic [KEY_W-1:0] k,
    input logic [4:0]       r
  );
    logic [KEY_W-1:0] t;
    t = {k[18:0], k[79:19]};
    t[79:76] = SBOX[t[79:76]];
    t[19:15] = t[19:15] ^ r;
    return t;
  endfunction

  // Exact inverse of fwd_upd: undo the XOR, the S-box, then the rotation.
  function automatic logic [KEY_W-1:0] inv_upd(
    input logic [KEY_W-1:0] k,
    input logic [4:0]       r
  );
    logic [KEY_W-1:0] t;
    t = k;
    t[19:15] = t[19:15] ^ r;
    t[79:76] = INV_SBOX[t[79:76]];
    return {t[60:0], t[79:61]};
  endfunction

  data_restore u_restore (
    .Data_ib    (st),
    .RoundKey_ib(key[79:16]),
    .Data_ob    (restored)
  );

  always_ff @(posedge Clk_ik or posedge Reset_ir) begin
    if (Reset_ir) cur <= IDLE;
    else          cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    unique case (cur)
      IDLE:    if (Start_i) nxt = EXPAND;
      EXPAND:  if (rc == RMAX) nxt = WHITEN;
      WHITEN:  nxt = DECRYPT;
      DECRYPT: if (rc == 5'd1) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk_ik or posedge Reset_ir) begin
    if (Reset_ir) begin
      st      <= '0;
      key     <= '0;
      rc      <= '0;
      Data_ob <= '0;
      Busy_o  <= 1'b0;
      Done_o  <= 1'b0;
    end else begin
      unique case (cur)
        IDLE: begin
          if (Start_i) begin
            st     <= Cipher_ib;
            key    <= Key_ib;
            rc     <= 5'd1;
            Busy_o <= 1'b1;
            Done_o <= 1'b0;
          end
        end
        EXPAND: begin
          key <= fwd_upd(key, rc);
          if (rc != RMAX) rc <= rc + 5'd1;
        end
        WHITEN: begin
          st  <= st ^ key[79:16];
          key <= inv_upd(key, RMAX);
          rc  <= RMAX;
        end
        DECRYPT: begin
          st <= restored;
          if (rc > 5'd1) begin
            key <= inv_upd(key, rc - 5'd1);
            rc  <= rc - 5'd1;
          end else begin
            Data_ob <= restored;
            Done_o  <= 1'b1;
            Busy_o  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_present_decrypt.sv
// Self-checking bench: reference PRESENT cipher model plus cycle scoreboard.
module tb_present_decrypt;
  localparam int R = 31;

  localparam logic [3:0] SB [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [79:0] key;
  logic [63:0] cipher;
  logic [63:0] data;
  logic        busy;
  logic        done;

  int ncmp = 0;
  int nerr = 0;
  int nvec = 0;
  bit armed = 0;

  logic        mbusy = 0;
  logic        mdone = 0;
  logic [63:0] mdata = '0;
  logic [63:0] mexp = '0;
  int          mcnt = 0;

  present_decrypt #(.ROUNDS(R)) dut (
    .Clk_ik   (clk),
    .Reset_ir (rst),
    .Start_i  (start),
    .Key_ib   (key),
    .Cipher_ib(cipher),
    .Data_ob  (data),
    .Busy_o   (busy),
    .Done_o   (done)
  );

  always #5 clk = ~clk;

  function automatic int pmap(input int j);
    return (j == 63) ? 63 : (j * 16) % 63;
  endfunction

  function automatic logic [79:0] kupd(input logic [79:0] k, input int i);
    logic [79:0] t;
    t = (k << 61) | (k >> 19);
    t[79:76] = SB[t[79:76]];
    t = t ^ (80'(i) << 15);
    return t;
  endfunction

  function automatic logic [3:0] sinv(input logic [3:0] y);
    logic [3:0] r;
    r = '0;
    for (int v = 0; v < 16; v++) if (SB[v] == y) r = 4'(v);
    return r;
  endfunction

  function automatic logic [63:0] enc(input logic [63:0] pt, input logic [79:0] k0);
    logic [63:0] s, u;
    logic [79:0] k;
    s = pt;
    k = k0;
    for (int i = 1; i <= R; i++) begin
      s = s ^ k[79:16];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = SB[s[4*n +: 4]];
      u = '0;
      for (int j = 0; j < 64; j++) u[pmap(j)] = s[j];
      s = u;
      k = kupd(k, i);
    end
    return s ^ k[79:16];
  endfunction

  function automatic logic [63:0] dec(input logic [63:0] ct, input logic [79:0] k0);
    logic [63:0] rk [R+2];
    logic [63:0] s, u;
    logic [79:0] k;
    k = k0;
    for (int i = 1; i <= R + 1; i++) begin
      rk[i] = k[79:16];
      if (i <= R) k = kupd(k, i);
    end
    s = ct ^ rk[R+1];
    for (int i = R; i >= 1; i--) begin
      u = '0;
      for (int j = 0; j < 64; j++) u[j] = s[pmap(j)];
      for (int n = 0; n < 16; n++) u[4*n +: 4] = sinv(u[4*n +: 4]);
      s = u ^ rk[i];
    end
    return s;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-level scoreboard: a request occupies 2R+1 edges after acceptance.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mbusy = 0;
      mdone = 0;
      mdata = '0;
      mcnt  = 0;
    end else if (!mbusy) begin
      if (start === 1'b1) begin
        mbusy = 1;
        mdone = 0;
        mcnt  = 2 * R + 1;
        mexp  = dec(cipher, key);
      end
    end else begin
      mcnt--;
      if (mcnt == 0) begin
        mbusy = 0;
        mdone = 1;
        mdata = mexp;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("cyc_busy", 64'(busy), 64'(mbusy));
      chk("cyc_done", 64'(done), 64'(mdone));
      chk("cyc_data", data, mdata);
    end
  end

  task automatic run_req(
    input  logic [79:0] k,
    input  logic [63:0] c,
    input  bit          noise,
    output int          lat,
    output int          bcnt
  );
    @(negedge clk);
    key = k;
    cipher = c;
    start = 1'b1;
    nvec++;
    lat = 0;
    bcnt = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) begin
        start = 1'b0;
        key = 80'({$urandom, $urandom, $urandom});
        cipher = {$urandom, $urandom};
      end else if (noise && lat < 55) begin
        start = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
      end
      if (busy) bcnt++;
    end while (!done && lat < 200);
    chk("req_done", 64'(done), 64'd1);
    lat = lat - 1;
  endtask

  initial begin
    int lat, bc;
    logic [63:0] pt, ct;
    logic [79:0] k;

    rst = 1'b1;
    start = 1'b0;
    key = '0;
    cipher = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", data, 64'h0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    armed = 1;

    chk("model_k0_p0", enc(64'h0, 80'h0), 64'h5579C1387B228445);
    chk("model_kF_p0", enc(64'h0, {80{1'b1}}), 64'hE72C46C0F5945049);
    chk("model_k0_pF", enc({64{1'b1}}, 80'h0), 64'hA112FFC72F68417B);
    chk("model_kF_pF", enc({64{1'b1}}, {80{1'b1}}), 64'h3333DCD3213210D2);
    chk("model_dec", dec(64'h5579C1387B228445, 80'h0), 64'h0);

    run_req(80'h0, 64'h5579C1387B228445, 0, lat, bc);
    chk("kat1_data", data, 64'h0);
    chk("kat1_latency", 64'(lat), 64'd63);
    chk("kat1_busy_cycles", 64'(bc), 64'd63);
    run_req({80{1'b1}}, 64'hE72C46C0F5945049, 0, lat, bc);
    chk("kat2_data", data, 64'h0);
    run_req(80'h0, 64'hA112FFC72F68417B, 0, lat, bc);
    chk("kat3_data", data, {64{1'b1}});
    run_req({80{1'b1}}, 64'h3333DCD3213210D2, 0, lat, bc);
    chk("kat4_data", data, {64{1'b1}});
    chk("kat4_latency", 64'(lat), 64'd63);

    // Start held high; inputs swapped mid-request feed the next request.
    @(negedge clk);
    key = {80{1'b1}};
    cipher = 64'hE72C46C0F5945049;
    start = 1'b1;
    nvec += 2;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 10) begin
        key = 80'h0;
        cipher = 64'hA112FFC72F68417B;
      end
    end while (!done && lat < 200);
    chk("held_first_data", data, 64'h0);
    chk("held_first_latency", 64'(lat - 1), 64'd63);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) chk("held_accept_done", 64'(done), 64'd0);
    end while (!done && lat < 200);
    start = 1'b0;
    chk("held_gap", 64'(lat), 64'd64);
    chk("held_second_data", data, {64{1'b1}});

    // Asynchronous reset in the middle of the inverse rounds.
    @(negedge clk);
    key = 80'h0;
    cipher = 64'h5579C1387B228445;
    start = 1'b1;
    nvec++;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (39) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_data", data, 64'h0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    run_req({80{1'b1}}, 64'h3333DCD3213210D2, 0, lat, bc);
    chk("post_abort_data", data, {64{1'b1}});

    for (int v = 0; v < 300; v++) begin
      pt = {$urandom, $urandom};
      k = 80'({$urandom, $urandom, $urandom});
      ct = enc(pt, k);
      run_req(k, ct, (v % 3) == 0, lat, bc);
      chk("rand_roundtrip", data, pt);
    end

    @(negedge clk);
    armed = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
